hazard_stall_ctrl: RTL and testbench

//  Parametrised ID-stage hazard/stall controller for the 5-stage MIPS pipeline.

---
 rtl/mips_pkg.sv | 37 +++
 rtl/hazard_decode.sv | 39 +++
 rtl/hazard_stall_ctrl.sv | 124 ++++++++++++
 tb/tb_hazard_stall_ctrl.sv | 214 +++++++++++++++++++++
 4 files changed

// File: rtl/mips_pkg.sv
// mips_pkg: opcode/funct constants and hazard FSM state encoding shared by the
// ID-stage hazard/stall controller.
`default_nettype none

package mips_pkg;

    localparam logic [5:0] OP_SPECIAL = 6'b000000;
    localparam logic [5:0] OP_J       = 6'b000010;
    localparam logic [5:0] OP_JAL     = 6'b000011;
    localparam logic [5:0] OP_BEQ     = 6'b000100;
    localparam logic [5:0] OP_BNE     = 6'b000101;
    localparam logic [5:0] OP_MADDU   = 6'b011100;
    localparam logic [5:0] OP_LW      = 6'b100011;
    localparam logic [5:0] OP_SW      = 6'b101011;

    localparam logic [5:0] FN_MULTU   = 6'b011001;

    localparam int CNT_W = 7;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_MUL    = 2'd1,
        ST_BUBBLE = 2'd2
    } state_t;

    // True when the rt field is a source operand; loads and immediates write rt instead.
    function automatic logic op_uses_rt(input logic [5:0] op);
        case (op)
            OP_SPECIAL, OP_MADDU, OP_BEQ, OP_BNE, OP_SW: return 1'b1;
            OP_LW:                                       return 1'b0;
            default:                                     return 1'b0;
        endcase
    endfunction

endpackage

`default_nettype wire

// File: rtl/hazard_decode.sv
// hazard_decode: combinational ID-stage classification of the instruction and
// load-use comparison against the load currently in EX.
`default_nettype none

module hazard_decode
    import mips_pkg::*;
(
    input  logic [31:0] id_instr,
    input  logic        ex_mem_read,
    input  logic [4:0]  ex_rt,
    output logic        mul_op,
    output logic        br_op,
    output logic        jmp_op,
    output logic        load_use
);

    logic [5:0] op;
    logic [4:0] rs;
    logic [4:0] rt;
    logic [5:0] funct;
    logic [9:0] unused_bits;

    assign op          = id_instr[31:26];
    assign rs          = id_instr[25:21];
    assign rt          = id_instr[20:16];
    assign funct       = id_instr[5:0];
    assign unused_bits = id_instr[15:6];

    // MULTU must be qualified by the SPECIAL opcode; funct alone aliases immediates.
    assign mul_op = ((op == OP_SPECIAL) && (funct == FN_MULTU)) || (op == OP_MADDU);
    assign br_op  = (op == OP_BEQ) || (op == OP_BNE);
    assign jmp_op = (op == OP_J)   || (op == OP_JAL);

    assign load_use = ex_mem_read && (ex_rt != 5'd0) &&
                      ((ex_rt == rs) || ((ex_rt == rt) && op_uses_rt(op)));

endmodule

`default_nettype wire

// File: rtl/hazard_stall_ctrl.sv
// hazard_stall_ctrl: ID-stage FSM driving IF/ID stall/flush for multi-cycle
// multiplies, branch/jump bubbles and load-use interlocks.
`default_nettype none

module hazard_stall_ctrl
    import mips_pkg::*;
#(
    parameter int MUL_CYCLES     = 32,
    parameter int BRANCH_BUBBLES = 1,
    parameter int JUMP_BUBBLES   = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             id_valid,
    input  logic [31:0]      id_instr,
    input  logic             ex_mem_read,
    input  logic [4:0]       ex_rt,
    output logic             stall,
    output logic             flush,
    output logic             mul_start,
    output logic             busy,
    output logic [CNT_W-1:0] cnt
);

    if ((MUL_CYCLES < 1) || (MUL_CYCLES > 127) ||
        (BRANCH_BUBBLES < 0) || (BRANCH_BUBBLES > 7) ||
        (JUMP_BUBBLES < 0) || (JUMP_BUBBLES > 7)) begin : g_bad_params
        $error("hazard_stall_ctrl: parameter out of range");
    end

    localparam logic [CNT_W-1:0] MUL_LOAD = CNT_W'(MUL_CYCLES - 1);
    localparam logic [CNT_W-1:0] BR_LOAD  = (BRANCH_BUBBLES > 0) ? CNT_W'(BRANCH_BUBBLES - 1) : '0;
    localparam logic [CNT_W-1:0] JMP_LOAD = (JUMP_BUBBLES > 0)   ? CNT_W'(JUMP_BUBBLES - 1)   : '0;

    logic mul_op;
    logic br_op;
    logic jmp_op;
    logic load_use;

    hazard_decode u_decode (
        .id_instr    (id_instr),
        .ex_mem_read (ex_mem_read),
        .ex_rt       (ex_rt),
        .mul_op      (mul_op),
        .br_op       (br_op),
        .jmp_op      (jmp_op),
        .load_use    (load_use)
    );

    state_t           state, state_nx;
    logic [CNT_W-1:0] cnt_q, cnt_nx;
    logic             stall_q, stall_nx;
    logic             flush_q, flush_nx;
    logic             lu_stall;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= ST_IDLE;
            cnt_q   <= '0;
            stall_q <= 1'b0;
            flush_q <= 1'b0;
        end else begin
            state   <= state_nx;
            cnt_q   <= cnt_nx;
            stall_q <= stall_nx;
            flush_q <= flush_nx;
        end
    end

    always_comb begin
        state_nx  = state;
        cnt_nx    = cnt_q;
        stall_nx  = stall_q;
        flush_nx  = flush_q;
        mul_start = 1'b0;
        lu_stall  = 1'b0;
        case (state)
            ST_IDLE: begin
                if (id_valid) begin
                    if (load_use) begin
                        lu_stall = 1'b1;
                    end else if (mul_op) begin
                        // The multiply itself advances to EX; younger instructions wait.
                        mul_start = 1'b1;
                        state_nx  = ST_MUL;
                        cnt_nx    = MUL_LOAD;
                        stall_nx  = 1'b1;
                    end else if (br_op && (BRANCH_BUBBLES > 0)) begin
                        state_nx = ST_BUBBLE;
                        cnt_nx   = BR_LOAD;
                        flush_nx = 1'b1;
                    end else if (jmp_op && (JUMP_BUBBLES > 0)) begin
                        state_nx = ST_BUBBLE;
                        cnt_nx   = JMP_LOAD;
                        flush_nx = 1'b1;
                    end
                end
            end
            ST_MUL, ST_BUBBLE: begin
                if (cnt_q == '0) begin
                    state_nx = ST_IDLE;
                    stall_nx = 1'b0;
                    flush_nx = 1'b0;
                end else begin
                    cnt_nx = cnt_q - 1'b1;
                end
            end
            default: begin
                state_nx = ST_IDLE;
                cnt_nx   = '0;
                stall_nx = 1'b0;
                flush_nx = 1'b0;
            end
        endcase
    end

    assign stall = stall_q | lu_stall;
    assign flush = flush_q;
    assign busy  = (state != ST_IDLE);
    assign cnt   = cnt_q;

endmodule

`default_nettype wire

// File: tb/tb_hazard_stall_ctrl.sv
// tb_hazard_stall_ctrl: directed vectors against two controller configurations
// (32/2/1 and 4/0/0) sharing the same ID/EX stimulus.
`default_nettype none

module tb_hazard_stall_ctrl;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        id_valid;
    logic [31:0] id_instr;
    logic        ex_mem_read;
    logic [4:0]  ex_rt;

    logic       a_stall, a_flush, a_mul_start, a_busy;
    logic [6:0] a_cnt;
    logic       b_stall, b_flush, b_mul_start, b_busy;
    logic [6:0] b_cnt;

    int n_cmp = 0;
    int n_err = 0;

    localparam logic [5:0] FN_ADD = 6'b100000;

    always #5 clk = ~clk;

    hazard_stall_ctrl #(.MUL_CYCLES(32), .BRANCH_BUBBLES(2), .JUMP_BUBBLES(1)) dut_a (
        .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_instr(id_instr),
        .ex_mem_read(ex_mem_read), .ex_rt(ex_rt),
        .stall(a_stall), .flush(a_flush), .mul_start(a_mul_start), .busy(a_busy), .cnt(a_cnt)
    );

    hazard_stall_ctrl #(.MUL_CYCLES(4), .BRANCH_BUBBLES(0), .JUMP_BUBBLES(0)) dut_b (
        .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_instr(id_instr),
        .ex_mem_read(ex_mem_read), .ex_rt(ex_rt),
        .stall(b_stall), .flush(b_flush), .mul_start(b_mul_start), .busy(b_busy), .cnt(b_cnt)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic mid();
        @(negedge clk);
    endtask

    function automatic logic [31:0] rtype(input logic [4:0] rs, input logic [4:0] rt,
                                          input logic [4:0] rd, input logic [5:0] fn);
        return {6'b000000, rs, rt, rd, 5'd0, fn};
    endfunction

    function automatic logic [31:0] itype(input logic [5:0] op, input logic [4:0] rs,
                                          input logic [4:0] rt, input logic [15:0] imm);
        return {op, rs, rt, imm};
    endfunction

    initial begin
        #1_000_000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1, "timeout");
    end

    initial begin
        rst_n = 1'b0; id_valid = 1'b0; id_instr = '0; ex_mem_read = 1'b0; ex_rt = '0;
        repeat (2) tick();
        mid();
        chk("rst stall", a_stall, 0);
        chk("rst flush", a_flush, 0);
        chk("rst mul_start", a_mul_start, 0);
        chk("rst busy", a_busy, 0);
        chk("rst cnt", a_cnt, 0);
        tick(); rst_n = 1'b1;

        // MULTU on the 32-cycle controller
        tick(); id_valid = 1'b1; id_instr = rtype(5'd5, 5'd6, 5'd0, 6'b011001);
        mid();
        chk("multu mul_start T", a_mul_start, 1);
        chk("multu stall T", a_stall, 0);
        tick(); id_valid = 1'b0; id_instr = '0;
        mid();
        chk("multu mul_start T+1", a_mul_start, 0);
        chk("multu busy T+1", a_busy, 1);
        chk("multu cnt T+1", a_cnt, 31);
        for (int k = 1; k <= 32; k++) begin
            chk($sformatf("multu stall T+%0d", k), a_stall, 1);
            tick(); mid();
        end
        chk("multu stall T+33", a_stall, 0);
        chk("multu busy T+33", a_busy, 0);

        // MADDU on the 4-cycle controller, then back-to-back reissue
        tick(); id_valid = 1'b1; id_instr = {6'b011100, 5'd7, 5'd8, 10'd0, 6'b000001};
        mid();
        chk("maddu mul_start T", b_mul_start, 1);
        chk("maddu stall T", b_stall, 0);
        for (int k = 1; k <= 4; k++) begin
            tick(); id_valid = 1'b0;
            mid();
            chk($sformatf("maddu cnt T+%0d", k), b_cnt, 32'(4 - k));
            chk($sformatf("maddu stall T+%0d", k), b_stall, 1);
        end
        tick(); id_valid = 1'b1;
        mid();
        chk("maddu busy T+5", b_busy, 0);
        chk("maddu stall T+5", b_stall, 0);
        chk("b2b mul_start", b_mul_start, 1);
        tick(); id_valid = 1'b0;
        mid();
        chk("b2b stall", b_stall, 1);
        for (int i = 0; i < 40 && (a_busy || b_busy); i++) begin
            tick(); mid();
        end
        chk("drain a busy", a_busy, 0);
        chk("drain b busy", b_busy, 0);

        // ADDI whose immediate low bits alias the MULTU funct
        tick(); id_valid = 1'b1; id_instr = itype(6'b001000, 5'd1, 5'd2, 16'h0019);
        mid();
        chk("alias mul_start", a_mul_start, 0);
        chk("alias stall", a_stall, 0);
        tick(); id_valid = 1'b0;
        mid();
        chk("alias busy", a_busy, 0);
        chk("alias stall next", a_stall, 0);

        // BEQ: two bubbles on a, none on b
        tick(); id_valid = 1'b1; id_instr = itype(6'b000100, 5'd1, 5'd2, 16'h0004);
        mid();
        chk("beq flush T", a_flush, 0);
        tick(); id_valid = 1'b0;
        mid();
        chk("beq flush T+1", a_flush, 1);
        chk("beq cnt T+1", a_cnt, 1);
        chk("beq stall T+1", a_stall, 0);
        chk("beq0 flush", b_flush, 0);
        chk("beq0 busy", b_busy, 0);
        tick(); mid();
        chk("beq flush T+2", a_flush, 1);
        chk("beq stall T+2", a_stall, 0);
        tick(); mid();
        chk("beq flush T+3", a_flush, 0);
        chk("beq busy T+3", a_busy, 0);

        // J: single bubble
        tick(); id_valid = 1'b1; id_instr = {6'b000010, 26'h10};
        mid();
        chk("j flush T", a_flush, 0);
        tick(); id_valid = 1'b0;
        mid();
        chk("j flush T+1", a_flush, 1);
        tick(); mid();
        chk("j flush T+2", a_flush, 0);

        // Load-use cases
        tick(); id_valid = 1'b1; ex_mem_read = 1'b1; ex_rt = 5'd5;
        id_instr = rtype(5'd5, 5'd6, 5'd3, FN_ADD);
        mid();
        chk("lu rs stall", a_stall, 1);
        chk("lu rs busy", a_busy, 0);
        chk("lu rs mul_start", a_mul_start, 0);
        tick(); ex_mem_read = 1'b0;
        mid();
        chk("lu cleared stall", a_stall, 0);
        tick(); ex_mem_read = 1'b1; id_instr = rtype(5'd6, 5'd5, 5'd3, FN_ADD);
        mid();
        chk("lu rt stall", a_stall, 1);
        tick(); id_instr = itype(6'b001000, 5'd6, 5'd5, 16'h0001);
        mid();
        chk("lu addi rt-dest stall", a_stall, 0);
        tick(); ex_rt = 5'd0; id_instr = rtype(5'd0, 5'd6, 5'd3, FN_ADD);
        mid();
        chk("lu r0 stall", a_stall, 0);
        tick(); ex_rt = 5'd5; id_instr = rtype(5'd5, 5'd6, 5'd0, 6'b011001);
        mid();
        chk("lu+mul stall", a_stall, 1);
        chk("lu+mul mul_start", a_mul_start, 0);
        tick(); ex_mem_read = 1'b0;
        mid();
        chk("lu+mul next mul_start", a_mul_start, 1);
        chk("lu+mul next stall", a_stall, 0);
        tick(); id_valid = 1'b0;
        mid();
        chk("lu+mul mul stall", a_stall, 1);

        // Asynchronous reset in the middle of the multiply
        repeat (3) tick();
        #1 rst_n = 1'b0;
        #1;
        chk("async rst stall", a_stall, 0);
        chk("async rst busy", a_busy, 0);
        chk("async rst cnt", a_cnt, 0);
        chk("async rst mul_start", a_mul_start, 0);
        tick(); rst_n = 1'b1;
        mid();
        chk("post rst stall", a_stall, 0);
        chk("post rst busy", a_busy, 0);
        tick(); mid();
        chk("post rst stall 2", a_stall, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

`default_nettype wire
